// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus used by imem_loader.
//   byte_valid/byte_data : stream byte offered by the host source
//   byte_ready           : loader accepts the byte this cycle (transfer = valid & ready)
//   we/waddr/wdata       : imem write port; waddr/wdata are meaningful only while we=1
// The loader uses the slave modport. The host/imem side uses the master modport.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, we, waddr, wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader.
// It receives a program as a byte stream. The first byte is the word count N. It is followed by
// N*4 data bytes. The loader packs the data bytes LSB-first into 32-bit words and writes them to
// byte addresses 0, 4, 8, and so on. The CPU is held stalled for the whole load.
// Ports:
//   clk, reset (synchronous, active-high)
//   start      : begin a load. It is sampled only while idle.
//   bus        : byte stream in, imem write port out (imem_loader_if.slave)
//   cpu_stall  : high from the accepted start until the DONE cycle has passed
//   busy       : high while receiving or writing (HDR/DATA/WRITE)
//   done       : one-cycle pulse at the end of a load, both on success and on error
//   err        : sticky error flag (bad length or timeout). It is cleared by the next start.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           cpu_stall,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [7:0]        n_words;
  logic [7:0]        words_done;
  logic [1:0]        byte_idx;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;

  logic xfer;
  logic timeout_hit;
  logic bad_len;
  logic last_word;

  assign xfer        = bus.byte_valid && bus.byte_ready;
  // This cycle is the TIMEOUT-th consecutive idle cycle in HDR/DATA.
  assign timeout_hit = !xfer && (tcnt == TW'(TIMEOUT - 1));
  assign bad_len     = (bus.byte_data == 8'd0) || (bus.byte_data > 8'(MAX_WORDS));
  assign last_word   = (8'(words_done + 8'd1) == n_words);

  // NOTE: sequential state is updated with non-blocking assignments only.
  // A blocking assignment here would let later readers in the same edge see the new value.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // NOTE: every output of this block gets a default first.
  // Any path that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_n        = state;
    bus.byte_ready = 1'b0;
    bus.we         = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    cpu_stall      = 1'b1;
    unique case (state)
      S_IDLE: begin
        cpu_stall = 1'b0;
        if (start) state_n = S_HDR;
      end
      S_HDR: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (xfer)             state_n = bad_len ? S_DONE : S_DATA;
        else if (timeout_hit) state_n = S_DONE;
      end
      S_DATA: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (xfer && byte_idx == 2'd3) state_n = S_WRITE;
        else if (timeout_hit)         state_n = S_DONE;
      end
      S_WRITE: begin
        bus.we  = 1'b1;
        busy    = 1'b1;
        state_n = last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: length latch, byte packing, address stepping, timeout counter and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_words    <= '0;
      words_done <= '0;
      byte_idx   <= '0;
      tcnt       <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            err        <= 1'b0;
            waddr_q    <= '0;
            words_done <= '0;
            byte_idx   <= '0;
            tcnt       <= '0;
          end
        end
        S_HDR: begin
          if (xfer) begin
            tcnt     <= '0;
            byte_idx <= '0;
            if (bad_len) err     <= 1'b1;
            else         n_words <= bus.byte_data;
          end else if (timeout_hit) begin
            err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DATA: begin
          if (xfer) begin
            wdata_q[8*byte_idx +: 8] <= bus.byte_data;
            byte_idx                 <= byte_idx + 1'b1;
            tcnt                     <= '0;
          end else if (timeout_hit) begin
            err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WRITE: begin
          waddr_q    <= waddr_q + ADDR_W'(4);
          words_done <= words_done + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
// The expected imem writes and the expected done/err results are queued when stimulus is issued.
// An independent negedge monitor pops them and compares whenever the DUT pulses we or done.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_stall, busy, done, err;

  imem_loader_if #(.ADDR_W(8)) bus();

  imem_loader #(.ADDR_W(8), .MAX_WORDS(64), .TIMEOUT(1024)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_stall (cpu_stall),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  bit          err_q[$];
  logic [31:0] prog [64];
  int          total = 0;
  int          bad   = 0;
  int          wr_count = 0;
  logic [7:0]  last_waddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.we === 1'b1) begin
      wr_count++;
      last_waddr = bus.waddr;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got addr=0x%02h data=0x%08h expected no write", bus.waddr, bus.wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", 32'(bus.waddr), 32'(e.addr));
        check("we_data", bus.wdata, e.data);
      end
    end
    if (reset === 1'b0 && done === 1'b1) begin
      if (err_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        bit e;
        e = err_q.pop_front();
        check("done_err", 32'(err), 32'(e));
        check("done_busy", 32'(busy), 32'd0);
        check("done_cpu_stall", 32'(cpu_stall), 32'd1);
      end
    end
  end

  // All drivers below are called at a negedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    guard = 0;
    while (bus.byte_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (bus.byte_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL byte_ready_wait: got ready=0 expected ready=1 within 2000 cycles");
    end
    @(negedge clk);  // transfer happened on the posedge just passed
    bus.byte_valid = 1'b0;
  endtask

  // Send the data bytes of prog[0..n_full-1], then extra_bytes bytes of the next word.
  // A word is expected to be written only once all four of its bytes are queued.
  task automatic send_words(input int n_full, input int extra_bytes);
    for (int i = 0; i < n_full; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3) exp_q.push_back('{addr: 8'(4 * i), data: prog[i]});
        send_byte(prog[i][8*k +: 8], int'($urandom_range(0, 3)));
      end
    end
    for (int k = 0; k < extra_bytes; k++)
      send_byte(prog[n_full][8*k +: 8], int'($urandom_range(0, 3)));
  endtask

  task automatic wait_done(input int bound);
    int cnt;
    cnt = 0;
    while (done !== 1'b1 && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_wait: got done=0 expected done within %0d cycles", bound);
    end
    @(negedge clk);
    check("idle_cpu_stall", 32'(cpu_stall), 32'd0);
  endtask

  task automatic good_load(input int n);
    pulse_start();
    check("start_clears_err", 32'(err), 32'd0);
    check("stall_after_start", 32'(cpu_stall), 32'd1);
    err_q.push_back(1'b0);
    send_byte(8'(n), int'($urandom_range(0, 3)));
    send_words(n, 0);
    wait_done(50);
  endtask

  task automatic random_prog();
    for (int i = 0; i < 64; i++) prog[i] = $urandom;
  endtask

  initial begin
    int cnt;
    int wr_base;
    reset          = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset, all outputs quiet
    for (int i = 0; i < 10; i++) begin
      check("reset_outputs",
            {bus.byte_ready, bus.we, bus.waddr, bus.wdata, cpu_stall, busy, done, err}, 32'd0);
      @(negedge clk);
    end

    // 2: directed two-word program
    prog[0] = 32'h0000_0093;
    prog[1] = 32'h0010_0113;
    good_load(2);
    check("t2_err", 32'(err), 32'd0);

    // 3: zero length is an error with no writes, next start clears err
    pulse_start();
    err_q.push_back(1'b1);
    send_byte(8'd0, 0);
    wait_done(10);
    check("t3_err_sticky", 32'(err), 32'd1);
    random_prog();
    good_load(3);

    // 4: over-length is rejected, maximum length fills the whole memory
    pulse_start();
    err_q.push_back(1'b1);
    send_byte(8'd65, 1);
    wait_done(10);
    check("t4_err_65", 32'(err), 32'd1);
    random_prog();
    wr_base = wr_count;
    good_load(64);
    check("t4_write_count", 32'(wr_count - wr_base), 32'd64);
    check("t4_last_waddr", 32'(last_waddr), 32'd252);

    // 5: a stall of TIMEOUT idle cycles mid-word aborts the load
    random_prog();
    pulse_start();
    err_q.push_back(1'b1);
    send_byte(8'd1, 0);
    send_words(0, 2);
    cnt = 0;
    while (done !== 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_timeout_cycles", 32'(cnt), 32'd1024);
    check("t5_err", 32'(err), 32'd1);
    @(negedge clk);
    random_prog();
    good_load(1);

    // 6: reset mid-load leaves word 0 written, and nothing is written after the reset
    random_prog();
    pulse_start();
    send_byte(8'd4, 0);
    send_words(1, 3);
    reset = 1'b1;
    @(negedge clk);
    check("t6_stall_after_reset", 32'(cpu_stall), 32'd0);
    check("t6_busy_after_reset", 32'(busy), 32'd0);
    check("t6_ready_after_reset", 32'(bus.byte_ready), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Random loads against the reference model
    for (int r = 0; r < 4; r++) begin
      random_prog();
      good_load(int'($urandom_range(1, 64)));
    end

    repeat (5) @(negedge clk);
    check("exp_writes_drained", 32'(exp_q.size()), 32'd0);
    check("exp_done_drained", 32'(err_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "simulation time limit");
  end

endmodule
